ifetch_unit: RTL

- Consumer side of the PC register. Each cycle it reads the current PC, fetches the instruction word at that address from instruction memory over a req/ack handshake, and buffers the {pc, instr} pairs for decode.
- Drives the PC register's write enable and new-PC value: sequential PC+4 on each completed fetch, or the redirect target on a branch.
- Sits between the PC register, instruction memory and the decode stage.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_buf.sv | 60 ++++++
 rtl/ifetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and the
// {pc, instr} entry that travels from memory to decode.
package ifetch_pkg;

    localparam int INSTR_BYTES   = 4;
    localparam int FETCH_ADDR_W  = 64;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    // Field widths track the default ADDR_W / INSTR_W of ifetch_unit.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
// Push and pop may coincide; flush empties the FIFO and wins over both.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: reads the PC, fetches over a single-outstanding
// req/ack handshake, buffers {pc, instr} for decode and drives the PC
// register update (PC+4 per completed fetch, or the redirect target).
// Optional build macro: IFETCH_ALIGN_CHECK_EN adds a sticky align_fault
// output that freezes fetching after a misaligned redirect target.
//
//   state  | meaning
//   IDLE   | no request outstanding; issue from pc_in when a slot is free
//   BUSY   | request outstanding at req_addr; ack pushes and may chain
//   SQUASH | outstanding request is stale; wait for ack and drop the data
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_write,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready
`ifdef IFETCH_ALIGN_CHECK_EN
   ,output logic               align_fault
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_addr_next;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_redirect_target;
    logic              r_imem_req;
    logic              w_push;
    logic              w_flush;
    logic              w_pop;
    logic              w_buf_full;
    logic              w_buf_empty;
    logic              w_fault_block;
    logic              w_room_issue;
    logic              w_room_chain;
    logic [CNT_W-1:0]  w_buf_count;
    logic [CNT_W-1:0]  w_occ_after_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_pop           = !w_buf_empty && id_ready;
    assign w_occ_after_pop = w_buf_count - CNT_W'(w_pop);
    // A request is only issued when its result is guaranteed a slot.
    assign w_room_issue    = !w_buf_full || w_pop;
    assign w_room_chain    = (w_occ_after_pop < CNT_W'(DEPTH - 1));
    assign w_seq_pc        = r_req_addr + ADDR_W'(INSTR_BYTES);
    assign w_push_entry    = {r_req_addr, imem_rdata};

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_align_fault;

    // Misaligned redirect target latches a fault that lasts until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_align_fault <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_align_fault <= 1'b1;
        end
    end

    assign align_fault       = r_align_fault;
    assign w_fault_block     = r_align_fault;
    assign w_redirect_target = redirect_pc;
`else
    assign w_fault_block     = 1'b0;
    // Mask rather than slice so every target bit feeds the logic.
    assign w_redirect_target = redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; redirect outranks ack while a request is outstanding.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!redirect && !w_fault_block && w_room_issue) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (redirect) begin
                    w_state_next = imem_ack ? IDLE : SQUASH;
                end else if (imem_ack) begin
                    w_state_next = w_room_chain ? BUSY : IDLE;
                end
            end
            SQUASH: begin
                if (imem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: PC update, buffer push/flush and the next request address.
    always_comb begin
        pc_write        = 1'b0;
        pc_next         = '0;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        w_req_addr_next = r_req_addr;
        if (!reset) begin
            if (redirect) begin
                pc_write = 1'b1;
                pc_next  = w_redirect_target;
                w_flush  = 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!redirect && !w_fault_block && w_room_issue) begin
                        w_req_addr_next = pc_in;
                    end
                end
                BUSY: begin
                    if (!redirect && imem_ack) begin
                        w_push   = 1'b1;
                        pc_write = 1'b1;
                        pc_next  = w_seq_pc;
                        if (w_room_chain) begin
                            w_req_addr_next = w_seq_pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered memory request; address holds while the request is up.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr <= '0;
            r_imem_req <= 1'b0;
        end else begin
            r_req_addr <= w_req_addr_next;
            r_imem_req <= (w_state_next != IDLE);
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_req_addr;

    ifetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_buf_count),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty)
    );

    assign id_valid = !w_buf_empty;
    assign id_pc    = w_head.pc;
    assign id_instr = w_head.instr;

endmodule
